// File: rtl/cnt_seq_pkg.sv
// Shared types for the counter sequence controller.
// Holds the FSM state encoding used by cnt_seq_ctrl.
// No logic lives here.
package cnt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/cnt_seq_ctrl.sv
// Purpose: sequences a 4-bit loadable counter through one-shot or periodic runs of 16-preset counts.
// Latency: start -> LOAD next cycle; terminal count reloads in the same cycle (gapless); done 1 cycle after final tc.
// Backpressure: none; start is ignored while busy, stop aborts LOAD/RUN. Optional irq via CNT_SEQ_IRQ_EN.
module cnt_seq_ctrl
  import cnt_seq_pkg::*;
#(
  parameter int REPEAT_W = 4
) (
  input  logic                CP,
  input  logic                MR,
  input  logic                start,
  input  logic                stop,
  input  logic                oneshot,
  input  logic [3:0]          preset,
  input  logic [REPEAT_W-1:0] repeat_i,
  input  logic                cnt_tc,
  output logic                cnt_pe_n,
  output logic                cnt_cep,
  output logic                cnt_cet,
  output logic [3:0]          cnt_d,
  output logic                busy,
  output logic                done,
  output logic [REPEAT_W-1:0] period_cnt
`ifdef CNT_SEQ_IRQ_EN
  ,
  output logic                irq,
  input  logic                irq_clr
`endif
);

  localparam logic [REPEAT_W-1:0] PERIOD_ONE = {{(REPEAT_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [3:0]          preset_q, preset_d;
  logic [REPEAT_W-1:0] repeat_q, repeat_d;
  logic [REPEAT_W-1:0] period_q, period_d;
  logic                oneshot_q, oneshot_d;

  logic                [REPEAT_W-1:0] period_inc;
  logic                tc_run;
  logic                last_period;
  logic                reload;

  // Terminal count in RUN, unless an abort is pending; stop outranks tc.
  assign period_inc  = period_q + PERIOD_ONE;
  assign tc_run      = (state_q == RUN) && cnt_tc && !stop;
  assign last_period = oneshot_q || ((repeat_q != '0) && (period_inc == repeat_q));
  assign reload      = tc_run && !last_period;

  // Next-state and latched-parameter update.
  always_comb begin
    state_d   = state_q;
    preset_d  = preset_q;
    repeat_d  = repeat_q;
    period_d  = period_q;
    oneshot_d = oneshot_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          preset_d  = preset;
          repeat_d  = repeat_i;
          oneshot_d = oneshot;
          period_d  = '0;
        end
      end
      LOAD: state_d = stop ? IDLE : RUN;
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_tc) begin
          period_d = period_inc;
          state_d  = last_period ? DONE : RUN;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state and latched sequence parameters.
  always_ff @(posedge CP or negedge MR) begin
    if (!MR) begin
      state_q   <= IDLE;
      preset_q  <= '0;
      repeat_q  <= '0;
      period_q  <= '0;
      oneshot_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      preset_q  <= preset_d;
      repeat_q  <= repeat_d;
      period_q  <= period_d;
      oneshot_q <= oneshot_d;
    end
  end

  // Counter controls: load in LOAD, and a same-cycle reload on a non-final tc.
  assign cnt_pe_n   = !((state_q == LOAD) || reload);
  assign cnt_d      = cnt_pe_n ? 4'h0 : preset_q;
  assign cnt_cep    = (state_q == RUN);
  assign cnt_cet    = (state_q == RUN);
  assign busy       = (state_q == LOAD) || (state_q == RUN);
  assign done       = (state_q == DONE);
  assign period_cnt = period_q;

`ifdef CNT_SEQ_IRQ_EN
  logic irq_q;

  // Sticky interrupt: set by completion, cleared by irq_clr; set has priority.
  always_ff @(posedge CP or negedge MR) begin
    if (!MR) begin
      irq_q <= 1'b0;
    end else if (state_q == DONE) begin
      irq_q <= 1'b1;
    end else if (irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Bench for cnt_seq_ctrl driving a behavioural 4-bit synchronous loadable counter.
// Completion pulses are checked against a queue of expected period counts.
// Build with CNT_SEQ_IRQ_EN defined to include the interrupt checks.
module tb_cnt_seq_ctrl;

  localparam int RW = 4;

  logic          CP = 1'b0;
  logic          MR = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          oneshot = 1'b0;
  logic [3:0]    preset = 4'h0;
  logic [RW-1:0] repeat_i = '0;
  logic          cnt_tc;
  logic          cnt_pe_n, cnt_cep, cnt_cet;
  logic [3:0]    cnt_d;
  logic          busy, done;
  logic [RW-1:0] period_cnt;
  logic [3:0]    cnt_q;
`ifdef CNT_SEQ_IRQ_EN
  logic          irq;
  logic          irq_clr = 1'b0;
`endif

  int          n_assert = 0;
  int          n_fail = 0;
  int unsigned done_exp_q[$];
  int unsigned done_exp;
  logic [3:0]  exp_seq [6];
  int          run_cnt, n_seq, n_tc;
  logic        got_done;

  always #5 CP = ~CP;

  cnt_seq_ctrl #(.REPEAT_W(RW)) dut (
    .CP        (CP),
    .MR        (MR),
    .start     (start),
    .stop      (stop),
    .oneshot   (oneshot),
    .preset    (preset),
    .repeat_i  (repeat_i),
    .cnt_tc    (cnt_tc),
    .cnt_pe_n  (cnt_pe_n),
    .cnt_cep   (cnt_cep),
    .cnt_cet   (cnt_cet),
    .cnt_d     (cnt_d),
    .busy      (busy),
    .done      (done),
    .period_cnt(period_cnt)
`ifdef CNT_SEQ_IRQ_EN
    ,
    .irq       (irq),
    .irq_clr   (irq_clr)
`endif
  );

  // Controlled counter: synchronous load has priority over counting; tc gated by cet.
  always_ff @(posedge CP or negedge MR) begin
    if (!MR)            cnt_q <= 4'h0;
    else if (!cnt_pe_n) cnt_q <= cnt_d;
    else if (cnt_cep && cnt_cet) cnt_q <= cnt_q + 4'h1;
  end
  assign cnt_tc = cnt_cet && (cnt_q == 4'hF);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every done pulse must match the oldest outstanding expected period count.
  always @(negedge CP) begin
    if (MR && done) begin
      if (done_exp_q.size() == 0) begin
        chk("done_unexpected", 32'(done), 32'd0);
      end else begin
        done_exp = done_exp_q.pop_front();
        chk("done_period", 32'(period_cnt), done_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    exp_seq = '{4'hE, 4'hF, 4'hE, 4'hF, 4'hE, 4'hF};

    // Reset state
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pe_n", 32'(cnt_pe_n), 32'd1);
    chk("rst_cep", 32'(cnt_cep), 32'd0);
    chk("rst_cet", 32'(cnt_cet), 32'd0);
    chk("rst_d", 32'(cnt_d), 32'd0);
    chk("rst_period", 32'(period_cnt), 32'd0);
`ifdef CNT_SEQ_IRQ_EN
    chk("rst_irq", 32'(irq), 32'd0);
`endif
    @(negedge CP); MR = 1'b1;
    @(negedge CP);

    // One-shot, preset C
    oneshot = 1'b1; preset = 4'hC; repeat_i = '0; start = 1'b1;
    done_exp_q.push_back(1);
    @(negedge CP); start = 1'b0;
    chk("os_load_pe_n", 32'(cnt_pe_n), 32'd0);
    chk("os_load_d", 32'(cnt_d), 32'hC);
    chk("os_load_busy", 32'(busy), 32'd1);
    chk("os_load_cep", 32'(cnt_cep), 32'd0);
    @(negedge CP);
    chk("os_run_cep", 32'(cnt_cep), 32'd1);
    chk("os_run_cet", 32'(cnt_cet), 32'd1);
    chk("os_run_pe_n", 32'(cnt_pe_n), 32'd1);
    chk("os_run_q", 32'(cnt_q), 32'hC);
    run_cnt = 0;
    while (!cnt_tc && run_cnt < 20) begin
      run_cnt++;
      @(negedge CP);
    end
    chk("os_tc_seen", 32'(cnt_tc), 32'd1);
    chk("os_run_cycles", 32'(run_cnt), 32'd3);
    chk("os_tc_pe_n_held", 32'(cnt_pe_n), 32'd1);
    @(negedge CP);
    chk("os_done", 32'(done), 32'd1);
    chk("os_done_cep", 32'(cnt_cep), 32'd0);
    chk("os_done_busy", 32'(busy), 32'd0);
    @(negedge CP);
    chk("os_idle_done", 32'(done), 32'd0);
    chk("os_idle_busy", 32'(busy), 32'd0);
    chk("os_idle_period", 32'(period_cnt), 32'd1);
`ifdef CNT_SEQ_IRQ_EN
    chk("irq_set", 32'(irq), 32'd1);
    repeat (3) @(negedge CP);
    chk("irq_hold", 32'(irq), 32'd1);
    irq_clr = 1'b1;
    @(negedge CP); irq_clr = 1'b0;
    chk("irq_cleared", 32'(irq), 32'd0);
`endif

    // Periodic, preset E, three periods
    oneshot = 1'b0; preset = 4'hE; repeat_i = 4'd3; start = 1'b1;
    done_exp_q.push_back(3);
    @(negedge CP); start = 1'b0;
    n_seq = 0; n_tc = 0; got_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CP);
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (cnt_cep) begin
        if (n_seq < 6) chk($sformatf("per_seq%0d", n_seq), 32'(cnt_q), 32'(exp_seq[n_seq]));
        n_seq++;
        if (cnt_tc) begin
          n_tc++;
          if (n_tc < 3) begin
            chk("per_reload_pe_n", 32'(cnt_pe_n), 32'd0);
            chk("per_reload_d", 32'(cnt_d), 32'hE);
          end else begin
            chk("per_last_pe_n", 32'(cnt_pe_n), 32'd1);
          end
        end
      end
    end
    chk("per_done_seen", 32'(got_done), 32'd1);
    chk("per_len", 32'(n_seq), 32'd6);
    chk("per_tcs", 32'(n_tc), 32'd3);
    @(negedge CP);
    chk("per_period", 32'(period_cnt), 32'd3);
    chk("per_busy", 32'(busy), 32'd0);

    // Unlimited, preset F: reload every cycle, period count wraps; then stop on a tc
    preset = 4'hF; repeat_i = '0; start = 1'b1;
    @(negedge CP); start = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(negedge CP);
      chk($sformatf("ul_tc%0d", i), 32'(cnt_tc), 32'd1);
      chk($sformatf("ul_pe_n%0d", i), 32'(cnt_pe_n), 32'd0);
      chk($sformatf("ul_q%0d", i), 32'(cnt_q), 32'hF);
      chk($sformatf("ul_period%0d", i), 32'(period_cnt), 32'(i % 16));
    end
    @(negedge CP);
    chk("stop_tc_present", 32'(cnt_tc), 32'd1);
    stop = 1'b1;
    #1;
    chk("stop_tc_no_reload", 32'(cnt_pe_n), 32'd1);
    @(negedge CP); stop = 1'b0;
    chk("stop_idle_busy", 32'(busy), 32'd0);
    chk("stop_idle_done", 32'(done), 32'd0);
    chk("stop_idle_cep", 32'(cnt_cep), 32'd0);
    chk("stop_period_kept", 32'(period_cnt), 32'd2);
    chk("stop_cnt_wrapped", 32'(cnt_q), 32'h0);

    // Reset mid-RUN, then a normal one-shot
    preset = 4'hE; repeat_i = 4'd5; start = 1'b1;
    @(negedge CP); start = 1'b0;
    repeat (4) @(negedge CP);
    chk("mr_pre_period", 32'(period_cnt), 32'd1);
    MR = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_pe_n", 32'(cnt_pe_n), 32'd1);
    chk("mr_cep", 32'(cnt_cep), 32'd0);
    chk("mr_cet", 32'(cnt_cet), 32'd0);
    chk("mr_d", 32'(cnt_d), 32'd0);
    chk("mr_period", 32'(period_cnt), 32'd0);
    @(negedge CP); MR = 1'b1;
    @(negedge CP);
    oneshot = 1'b1; preset = 4'hC; repeat_i = '0; start = 1'b1;
    done_exp_q.push_back(1);
    @(negedge CP); start = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CP);
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    chk("mr_after_done", 32'(got_done), 32'd1);
`ifdef CNT_SEQ_IRQ_EN
    chk("irq_before_set", 32'(irq), 32'd0);
    irq_clr = 1'b1;
`endif
    @(negedge CP);
`ifdef CNT_SEQ_IRQ_EN
    irq_clr = 1'b0;
    chk("irq_set_wins", 32'(irq), 32'd1);
`endif
    chk("mr_after_busy", 32'(busy), 32'd0);
    chk("mr_after_period", 32'(period_cnt), 32'd1);

    repeat (2) @(negedge CP);
    chk("sb_drained", 32'(done_exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
